// File: rtl/sram_axi_bridge.sv
// Converts the core's inst and data SRAM-like ports into a single AXI master.
// It allows one outstanding read and one outstanding write, and data reads win arbitration.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_addrok,
    output logic        data_sram_dataok,

    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AWW  = 2'd1,
        W_B    = 2'd2
    } wstate_t;

    rstate_t     rstate;
    rstate_t     rstate_next;
    wstate_t     wstate;
    wstate_t     wstate_next;

    logic        rsel;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;

    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic        aw_done;
    logic        w_done;

    logic        data_rd_acc;
    logic        inst_rd_acc;
    logic        data_wr_acc;
    logic        aw_fire;
    logic        w_fire;

    // Acceptance is gated by resetn so no addrok can leak out while the bridge is held in reset.
    always_comb begin
        data_rd_acc = resetn && (rstate == R_IDLE) && (wstate == W_IDLE)
                      && data_sram_req && !data_sram_wr;
        inst_rd_acc = resetn && (rstate == R_IDLE) && inst_sram_req && !data_rd_acc;
        data_wr_acc = resetn && (wstate == W_IDLE) && data_sram_req && data_sram_wr
                      && !((rstate != R_IDLE) && rsel);
    end

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    // Read channel next state and outputs
    always_comb begin
        rstate_next      = rstate;
        arvalid          = 1'b0;
        rready           = 1'b0;
        inst_sram_dataok = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (data_rd_acc || inst_rd_acc) begin
                    rstate_next = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    rstate_next = R_R;
                end
            end
            R_R: begin
                rready           = 1'b1;
                inst_sram_dataok = rvalid && !rsel;
                if (rvalid) begin
                    rstate_next = R_IDLE;
                end
            end
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsel    <= 1'b0;
            rd_addr <= 32'd0;
            rd_size <= 3'd0;
        end else if (data_rd_acc) begin
            rsel    <= 1'b1;
            rd_addr <= data_sram_addr;
            rd_size <= {1'b0, data_sram_size};
        end else if (inst_rd_acc) begin
            rsel    <= 1'b0;
            rd_addr <= inst_sram_addr;
            rd_size <= 3'd2;
        end
    end

    // Write channel next state and outputs; AW and W complete independently
    always_comb begin
        wstate_next = wstate;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (data_wr_acc) begin
                    wstate_next = W_AWW;
                end
            end
            W_AWW: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    wstate_next = W_B;
                end
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wstate_next = W_IDLE;
                end
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_addr <= 32'd0;
            wr_size <= 3'd0;
            wr_strb <= 4'd0;
            wr_data <= 32'd0;
        end else if (data_wr_acc) begin
            wr_addr <= data_sram_addr;
            wr_size <= {1'b0, data_sram_size};
            wr_strb <= data_sram_wstrb;
            wr_data <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (data_wr_acc) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wstate == W_AWW) begin
            if (aw_fire) begin
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                w_done <= 1'b1;
            end
        end
    end

    // Only one data transaction is ever in flight, so read and write completions never collide here.
    always_comb begin
        inst_sram_addrok = inst_rd_acc;
        data_sram_addrok = data_rd_acc || data_wr_acc;
        data_sram_dataok = ((rstate == R_R) && rvalid && rsel)
                           || ((wstate == W_B) && bvalid);
        inst_sram_rdata  = rdata;
        data_sram_rdata  = rdata;
        araddr           = rd_addr;
        arsize           = rd_size;
        awaddr           = wr_addr;
        awsize           = wr_size;
        wstrb            = wr_strb;
        wdata            = wr_data;
    end

endmodule
